// File: rtl/boot_load_ctrl_pkg.sv
// Shared constants for the UART boot loader: destination codes, buffer widths
// and the loader FSM state encoding.
package common_params;

  localparam int IB_DW         = 3072;
  localparam int IB_DW_PB      = IB_DW / 8;
  localparam int I_D_MEM_DW_PB = 4;
  localparam int ADDR_WIDTH_PB = 2;

  localparam logic [7:0] I_MEM        = 8'h04;
  localparam logic [7:0] D_MEM        = 8'h02;
  localparam logic [7:0] IMAGE_BUFFER = 8'h01;
  localparam logic [7:0] CPU_RELEASE  = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CNT,
    DATA,
    WRITE
  } state_e;

  typedef enum logic [1:0] {
    DST_IMEM,
    DST_DMEM,
    DST_IB
  } dest_e;

endpackage

// File: rtl/boot_byte_packer.sv
// Little-endian byte packer: each accepted byte enters at the top and the
// register shifts right, so the first byte of a word ends up in bits [7:0].
module boot_byte_packer #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          shift,
  input  logic [7:0]    byte_in,
  output logic [DW-1:0] data,
  output logic          last,
  output logic          full
);

  localparam int NB = DW / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  logic [CW-1:0] cnt_q;
  logic [DW-1:0] data_q;
  logic          full_q;

  assign last = shift && (cnt_q == CW'(NB - 1));
  assign data = data_q;
  assign full = full_q;

  // NOTE: the data register is plain flops, not a RAM macro, so clearing it
  // in reset is cheap and keeps a discarded partial word from leaking out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      data_q <= '0;
      full_q <= 1'b0;
    end else if (shift) begin
      // NOTE: non-blocking so every register samples pre-edge values.
      data_q <= {byte_in, data_q[DW-1:8]};
      cnt_q  <= last ? '0 : cnt_q + 1'b1;
      full_q <= last;
    end
  end

endmodule

// File: rtl/boot_load_ctrl.sv
// UART boot loader: parses destination/address/count headers and streams the
// payload into instruction memory, data memory or the image buffer.
module boot_load_ctrl
  import common_params::*;
#(
  parameter int IB_DW      = common_params::IB_DW,
  parameter int ADDR_BYTES = common_params::ADDR_WIDTH_PB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_byte,
  input  logic             rx_valid,
  output logic             imem_we,
  output logic             dmem_we,
  output logic             ib_we,
  output logic [15:0]      wr_addr,
  output logic [31:0]      wr_word,
  output logic [IB_DW-1:0] ib_line,
  output logic             cpu_rst_n,
  output logic             busy,
  output logic             err
);

  localparam int HW  = 8 * ADDR_BYTES;
  localparam int HCW = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
  localparam int WDW = 8 * I_D_MEM_DW_PB;

  state_e         state_q, state_nxt;
  dest_e          dest_q, dest_nxt;
  logic [15:0]    addr_q, addr_nxt;
  logic [HW-1:0]  cnt_q, cnt_nxt, cnt_shift;
  logic [HCW-1:0] hdr_q, hdr_nxt;
  logic           cpu_q, cpu_nxt;
  logic           err_q, err_nxt;

  logic           shift_en, idle_cmd, hdr_last;
  logic           word_last, word_full, line_last, line_full, pack_last;
  logic [WDW-1:0] word_data;

  boot_byte_packer #(.DW(WDW)) u_word_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .shift   (shift_en && (dest_q != DST_IB)),
    .byte_in (rx_byte),
    .data    (word_data),
    .last    (word_last),
    .full    (word_full)
  );

  boot_byte_packer #(.DW(IB_DW)) u_line_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .shift   (shift_en && (dest_q == DST_IB)),
    .byte_in (rx_byte),
    .data    (ib_line),
    .last    (line_last),
    .full    (line_full)
  );

  assign pack_last = (dest_q == DST_IB) ? line_last : word_last;
  assign hdr_last  = (hdr_q == HCW'(ADDR_BYTES - 1));
  assign cnt_shift = (cnt_q << 8) | HW'(rx_byte);

  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_nxt = state_q;
    dest_nxt  = dest_q;
    addr_nxt  = addr_q;
    cnt_nxt   = cnt_q;
    hdr_nxt   = hdr_q;
    cpu_nxt   = cpu_q;
    err_nxt   = err_q;
    shift_en  = 1'b0;
    idle_cmd  = 1'b0;

    case (state_q)
      IDLE: idle_cmd = rx_valid;
      ADDR: begin
        if (rx_valid) begin
          addr_nxt = (addr_q << 8) | {8'h00, rx_byte};
          hdr_nxt  = hdr_last ? '0 : hdr_q + 1'b1;
          if (hdr_last) state_nxt = CNT;
        end
      end
      CNT: begin
        if (rx_valid) begin
          cnt_nxt = cnt_shift;
          hdr_nxt = hdr_last ? '0 : hdr_q + 1'b1;
          if (hdr_last) state_nxt = (cnt_shift == '0) ? IDLE : DATA;
        end
      end
      DATA: begin
        if (rx_valid) begin
          shift_en = 1'b1;
          if (pack_last) state_nxt = WRITE;
        end
      end
      WRITE: begin
        addr_nxt = addr_q + 16'd1;
        cnt_nxt  = cnt_q - HW'(1);
        if (cnt_q == HW'(1)) begin
          // A byte landing on the final write is a fresh command, not payload.
          state_nxt = IDLE;
          idle_cmd  = rx_valid;
        end else begin
          state_nxt = DATA;
          shift_en  = rx_valid;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (idle_cmd) begin
      case (rx_byte)
        I_MEM, D_MEM, IMAGE_BUFFER: begin
          dest_nxt  = (rx_byte == I_MEM) ? DST_IMEM :
                      (rx_byte == D_MEM) ? DST_DMEM : DST_IB;
          cpu_nxt   = 1'b0;
          hdr_nxt   = '0;
          state_nxt = ADDR;
        end
        CPU_RELEASE: cpu_nxt = 1'b1;
        default:     err_nxt = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dest_q  <= DST_IMEM;
      addr_q  <= '0;
      cnt_q   <= '0;
      hdr_q   <= '0;
      cpu_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      dest_q  <= dest_nxt;
      addr_q  <= addr_nxt;
      cnt_q   <= cnt_nxt;
      hdr_q   <= hdr_nxt;
      cpu_q   <= cpu_nxt;
      err_q   <= err_nxt;
    end
  end

  // Strobes are pure decodes of WRITE, so they are one cycle wide and exclusive.
  assign imem_we   = (state_q == WRITE) && (dest_q == DST_IMEM) && word_full;
  assign dmem_we   = (state_q == WRITE) && (dest_q == DST_DMEM) && word_full;
  assign ib_we     = (state_q == WRITE) && (dest_q == DST_IB)   && line_full;
  assign wr_addr   = addr_q;
  assign wr_word   = word_data;
  assign cpu_rst_n = cpu_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Directed bench for boot_load_ctrl: header parsing, word/line assembly,
// address wrap, error handling, abort on reset and back-to-back streaming.
module tb_boot_load_ctrl;

  localparam int IB_DW = 3072;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       rx_byte = 8'h00;
  logic             rx_valid = 1'b0;
  logic             imem_we, dmem_we, ib_we;
  logic [15:0]      wr_addr;
  logic [31:0]      wr_word;
  logic [IB_DW-1:0] ib_line;
  logic             cpu_rst_n, busy, err;

  boot_load_ctrl #(.IB_DW(IB_DW), .ADDR_BYTES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .imem_we   (imem_we),
    .dmem_we   (dmem_we),
    .ib_we     (ib_we),
    .wr_addr   (wr_addr),
    .wr_word   (wr_word),
    .ib_line   (ib_line),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  we;   // {imem, dmem, ib}
    logic [15:0] addr;
    logic [31:0] word;
    logic [7:0]  b0, b1, bh;
    int          cyc;
  } wr_t;

  wr_t act_q[$];
  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  last_cap = 0;

  always @(negedge clk) begin
    if (imem_we || dmem_we || ib_we) begin
      wr_t r;
      r.we   = {imem_we, dmem_we, ib_we};
      r.addr = wr_addr;
      r.word = wr_word;
      r.b0   = ib_line[7:0];
      r.b1   = ib_line[15:8];
      r.bh   = ib_line[IB_DW-1 -: 8];
      r.cyc  = cyc;
      act_q.push_back(r);
    end
  end

  task check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task send(input logic [7:0] b, input int gap);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    last_cap = cyc;
    rx_valid = 1'b0;
    rx_byte  = 8'hA5;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  task idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task expect_wr(input logic [2:0] we, input logic [15:0] addr, input logic [31:0] word,
                 input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] bh, input int c);
    wr_t r;
    r.we = we; r.addr = addr; r.word = word; r.b0 = b0; r.b1 = b1; r.bh = bh; r.cyc = c;
    exp_q.push_back(r);
  endtask

  task compare_writes(input string tag);
    check({tag, " write count"}, 64'(act_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      check($sformatf("%s[%0d] strobe", tag, i), 64'(act_q[i].we), 64'(exp_q[i].we));
      check($sformatf("%s[%0d] addr", tag, i), 64'(act_q[i].addr), 64'(exp_q[i].addr));
      if (exp_q[i].we == 3'b001) begin
        check($sformatf("%s[%0d] line[7:0]", tag, i), 64'(act_q[i].b0), 64'(exp_q[i].b0));
        check($sformatf("%s[%0d] line[15:8]", tag, i), 64'(act_q[i].b1), 64'(exp_q[i].b1));
        check($sformatf("%s[%0d] line top", tag, i), 64'(act_q[i].bh), 64'(exp_q[i].bh));
      end else begin
        check($sformatf("%s[%0d] word", tag, i), 64'(act_q[i].word), 64'(exp_q[i].word));
      end
      if (exp_q[i].cyc >= 0)
        check($sformatf("%s[%0d] latency", tag, i), 64'(act_q[i].cyc), 64'(exp_q[i].cyc));
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task check_reset(input string tag);
    check({tag, " imem_we"}, 64'(imem_we), 64'd0);
    check({tag, " dmem_we"}, 64'(dmem_we), 64'd0);
    check({tag, " ib_we"}, 64'(ib_we), 64'd0);
    check({tag, " wr_addr"}, 64'(wr_addr), 64'd0);
    check({tag, " wr_word"}, 64'(wr_word), 64'd0);
    check({tag, " ib_line nonzero"}, 64'(|ib_line), 64'd0);
    check({tag, " cpu_rst_n"}, 64'(cpu_rst_n), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " err"}, 64'(err), 64'd0);
  endtask

  initial begin
    logic [7:0] hdr_a[5] = '{8'h04, 8'h00, 8'h10, 8'h00, 8'h02};
    logic [7:0] hdr_b[5] = '{8'h02, 8'hFF, 8'hFF, 8'h00, 8'h02};
    logic [7:0] hdr_c[5] = '{8'h01, 8'h00, 8'h03, 8'h00, 8'h01};
    logic [7:0] hdr_f[5] = '{8'h04, 8'h00, 8'h40, 8'h00, 8'h03};
    int cap[3];

    // Reset state
    idle(3);
    check_reset("reset");
    rst_n = 1'b1;
    idle(1);

    // Two I_MEM words with idle gaps between bytes
    foreach (hdr_a[i]) send(hdr_a[i], 1);
    check("imem hdr cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    check("imem hdr busy", 64'(busy), 64'd1);
    for (int i = 0; i < 8; i++) send(8'h11 * (i + 1), 1);
    idle(3);
    expect_wr(3'b100, 16'h0010, 32'h44332211, 8'h0, 8'h0, 8'h0, -1);
    expect_wr(3'b100, 16'h0011, 32'h88776655, 8'h0, 8'h0, 8'h0, -1);
    compare_writes("imem");
    check("imem busy after", 64'(busy), 64'd0);

    // D_MEM address wrap
    foreach (hdr_b[i]) send(hdr_b[i], 2);
    for (int i = 0; i < 8; i++) send(8'(i + 1), 2);
    idle(3);
    expect_wr(3'b010, 16'hFFFF, 32'h04030201, 8'h0, 8'h0, 8'h0, -1);
    expect_wr(3'b010, 16'h0000, 32'h08070605, 8'h0, 8'h0, 8'h0, -1);
    compare_writes("dmem wrap");

    // One image-buffer line, bytes back to back
    foreach (hdr_c[i]) send(hdr_c[i], 0);
    for (int i = 0; i < IB_DW / 8; i++) send(8'(i % 256), 0);
    cap[0] = last_cap;
    idle(3);
    expect_wr(3'b001, 16'h0003, 32'h0, 8'h00, 8'h01, 8'h7F, cap[0]);
    compare_writes("ibuf");
    check("ibuf busy after", 64'(busy), 64'd0);

    // Illegal destination, then CPU release
    send(8'h07, 2);
    check("bad dest err", 64'(err), 64'd1);
    check("bad dest busy", 64'(busy), 64'd0);
    send(8'h00, 2);
    check("release cpu_rst_n", 64'(cpu_rst_n), 64'd1);
    check("release err sticky", 64'(err), 64'd1);
    compare_writes("bad dest");

    // Zero-count header
    send(8'h04, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    idle(2);
    check("zero cnt busy", 64'(busy), 64'd0);
    check("zero cnt cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    compare_writes("zero cnt");

    // Reset mid-word aborts the transfer
    send(8'h04, 0); send(8'h00, 0); send(8'h20, 0); send(8'h00, 0); send(8'h01, 0);
    send(8'hAA, 0); send(8'hBB, 0);
    check("abort busy before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    idle(1);
    check_reset("abort");
    rst_n = 1'b1;
    idle(6);
    compare_writes("abort");

    // Three I_MEM words with rx_valid held high across each WRITE
    foreach (hdr_f[i]) send(hdr_f[i], 0);
    for (int i = 0; i < 12; i++) begin
      send(8'(8'h10 + i), 0);
      if (i % 4 == 3) cap[i / 4] = last_cap;
    end
    idle(3);
    expect_wr(3'b100, 16'h0040, 32'h13121110, 8'h0, 8'h0, 8'h0, cap[0]);
    expect_wr(3'b100, 16'h0041, 32'h17161514, 8'h0, 8'h0, 8'h0, cap[1]);
    expect_wr(3'b100, 16'h0042, 32'h1B1A1918, 8'h0, 8'h0, 8'h0, cap[2]);
    compare_writes("b2b");
    check("b2b busy after", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/boot_load_ctrl.md
BOOT_LOAD_CTRL -- requirements
Module: boot_load_ctrl

Interface
REQ-001 SHALL have parameter IB_DW, default 3072, image-buffer line width in bits.
REQ-002 SHALL have parameter ADDR_BYTES, default 2, number of address bytes and of count bytes in the header.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port rx_byte, input, 8, received UART byte.
REQ-006 SHALL have port rx_valid, input, 1, one-cycle strobe marking rx_byte valid.
REQ-007 SHALL have port imem_we, output, 1, instruction-memory word write strobe.
REQ-008 SHALL have port dmem_we, output, 1, data-memory word write strobe.
REQ-009 SHALL have port ib_we, output, 1, image-buffer line write strobe.
REQ-010 SHALL have port wr_addr, output, 16, word/line address of the current write.
REQ-011 SHALL have port wr_word, output, 32, assembled word for I/D memory.
REQ-012 SHALL have port ib_line, output, IB_DW, assembled image-buffer line.
REQ-013 SHALL have port cpu_rst_n, output, 1, active-low CPU hold-reset.
REQ-014 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-015 SHALL have port err, output, 1, sticky flag for an illegal destination byte.

Function
REQ-016 SHALL run FSM states IDLE, ADDR, CNT, DATA, WRITE.
REQ-017 IDLE with rx_valid: byte 0x04 (I_MEM), 0x02 (D_MEM) or 0x01 (IMAGE_BUFFER) SHALL latch the destination, drive cpu_rst_n=0 and go to ADDR.
REQ-018 IDLE, byte 0x00 SHALL set cpu_rst_n=1 and stay in IDLE.
REQ-019 IDLE, any other byte SHALL set err=1 and stay in IDLE; err clears only on reset.
REQ-020 ADDR SHALL shift in ADDR_BYTES bytes, MSB first, as start address, then go to CNT.
REQ-021 CNT SHALL shift in ADDR_BYTES bytes, MSB first, as word count; count 0 SHALL return to IDLE with no writes.
REQ-022 DATA SHALL accept 4 bytes per word for I_MEM/D_MEM and IB_DW/8 (384) bytes per line for IMAGE_BUFFER, little-endian (first byte into bits [7:0]).
REQ-023 On the final byte of a word, the next cycle SHALL be WRITE: exactly one destination strobe high for one cycle, wr_addr = current address, data stable.
REQ-024 After WRITE, address SHALL increment by 1 (16-bit wrap 0xFFFF->0x0000) and remaining count decrement; next state DATA, or IDLE when count reaches 0.
REQ-025 rx_valid in WRITE SHALL be accepted as byte 0 of the next word (no byte lost).
REQ-026 Bytes arriving between rx_valid strobes SHALL be ignored; rx_valid outside DATA/ADDR/CNT/IDLE processing is never dropped.
REQ-027 Write strobes SHALL be mutually exclusive and low in all states except WRITE.
REQ-028 Latency: strobe asserted exactly 1 cycle after the rx_valid of the word's last byte.

Reset
REQ-029 rst_n=0 SHALL, at the next edge, force state IDLE, imem_we=dmem_we=ib_we=0, wr_addr=0, wr_word=0, ib_line=0, cpu_rst_n=0, busy=0, err=0, counters 0.
REQ-030 Reset mid-transfer SHALL abort it with no further strobes; a partially assembled word is discarded.

Structure
REQ-031 Destination codes I_MEM/D_MEM/IMAGE_BUFFER, IB_DW, IB_DW_PB, I_D_MEM_DW_PB, ADDR_WIDTH_PB and the FSM state enum SHALL live in the shared common_params package.
REQ-032 Byte assembly SHALL be a sub-module boot_byte_packer (parameterised width, shift-in, byte counter, full flag) reused for word and line.

Verification
REQ-033 Bytes 04,00,10,00,02,11,22,33,44,55,66,77,88 -> imem_we twice: addr 0x0010 data 0x44332211, addr 0x0011 data 0x88776655; busy low afterwards.
REQ-034 Bytes 02,FF,FF,00,02 + 8 data bytes -> dmem_we at 0xFFFF then 0x0000 (wrap).
REQ-035 Bytes 01,00,03,00,01 + 384 bytes of value i%256 -> single ib_we at 0x0003, ib_line[7:0]=0x00, ib_line[3071:3064]=0x7F.
REQ-036 Byte 07 in IDLE -> err=1, no strobe, state IDLE; then 00 -> cpu_rst_n=1, err stays 1.
REQ-037 Header 04,00,00,00,00 -> no strobe, return IDLE; rst_n low after 2 of 4 data bytes -> no strobe, all outputs at reset values.
REQ-038 rx_valid on consecutive cycles across a WRITE boundary -> all words written correctly, strobe exactly 1 cycle after last byte.
